// File: rtl/hipass_obu.sv
// ============================================================================
// Module   : hipass_obu
// Brief    : Toll on-board unit: answers a gate request with the card code,
//            deducts the fare on gate acknowledge, manages top-ups and a beep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hipass_obu #(
    parameter int RESP_DELAY  = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int BEEP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate_req,
    input  logic       gate_ack,
    input  logic       card_present,
    input  logic [3:0] card_id,
    input  logic       load_en,
    input  logic [7:0] load_val,
    input  logic [7:0] fare,
    output logic [3:0] hipass_out,
    output logic       tx_busy,
    output logic [7:0] balance,
    output logic       paid,
    output logic       low_bal,
    output logic       beep
);

    localparam int MAX_AB = (RESP_DELAY > HOLD_CYCLES) ? RESP_DELAY : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_AB > ACK_TIMEOUT) ? MAX_AB : ACK_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_C + 1);
    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

    localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(RESP_DELAY - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [BEEP_W-1:0] BEEP_LOAD  = BEEP_W'(BEEP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DELAY    = 3'd1,
        S_SEND     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          code_q, code_d;
    logic [7:0]          balance_q, balance_d;
    logic                paid_q, paid_d;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic                gate_req_q;

    logic                req_rise;
    logic                card_ok;
    logic                abort;
    logic                ack_take;
    logic [8:0]          load_sum;
    logic [7:0]          base_bal;

    assign req_rise = gate_req & ~gate_req_q;
    assign card_ok  = card_present && (card_id != 4'h0) && (card_id != 4'hF);
    assign abort    = ~gate_req | ~card_present;

    // Top-up saturates; a same-cycle deduction is taken from the topped-up value.
    assign load_sum = {1'b0, balance_q} + {1'b0, load_val};
    assign base_bal = load_en ? (load_sum[8] ? 8'hFF : load_sum[7:0]) : balance_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        balance_d  = base_bal;
        paid_d     = 1'b0;
        beep_cnt_d = (beep_cnt_q != '0) ? (beep_cnt_q - BEEP_W'(1)) : '0;
        ack_take   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_rise && card_ok && (balance_q >= fare)) begin
                    state_d = S_DELAY;
                    cnt_d   = '0;
                    code_d  = card_id;
                end
            end
            S_DELAY: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DELAY_LAST) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (gate_ack) begin
                    ack_take = 1'b1;
                    state_d  = S_COOLDOWN;
                    cnt_d    = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_ACK: begin
                if (gate_ack) begin
                    ack_take = 1'b1;
                    state_d  = S_COOLDOWN;
                    cnt_d    = '0;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_COOLDOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COOLDOWN: begin
                if (!gate_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (ack_take && (base_bal >= fare)) begin
            balance_d  = base_bal - fare;
            paid_d     = 1'b1;
            beep_cnt_d = BEEP_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            code_q     <= 4'h0;
            balance_q  <= 8'h00;
            paid_q     <= 1'b0;
            beep_cnt_q <= '0;
            gate_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            balance_q  <= balance_d;
            paid_q     <= paid_d;
            beep_cnt_q <= beep_cnt_d;
            gate_req_q <= gate_req;
        end
    end

    assign hipass_out = (state_q == S_SEND) ? code_q : 4'h0;
    assign tx_busy    = (state_q != S_IDLE);
    assign balance    = balance_q;
    assign paid       = paid_q;
    assign low_bal    = (balance_q < fare);
    assign beep       = (beep_cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_hipass_obu.sv
// ============================================================================
// Module   : tb_hipass_obu
// Brief    : Self-checking bench for hipass_obu using per-cycle vector records.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hipass_obu;

    logic       clk = 1'b0;
    logic       rst;
    logic       gate_req, gate_ack, card_present, load_en;
    logic [3:0] card_id;
    logic [7:0] load_val, fare;
    logic [3:0] hipass_out;
    logic       tx_busy, paid, low_bal, beep;
    logic [7:0] balance;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       gr, ga, cp;
        logic [3:0] id;
        logic       le;
        logic [7:0] lv, fr;
        logic [3:0] h;
        logic       b;
        logic [7:0] bal;
        logic       p, lo, bp;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[17];

    hipass_obu dut (
        .clk          (clk),
        .rst          (rst),
        .gate_req     (gate_req),
        .gate_ack     (gate_ack),
        .card_present (card_present),
        .card_id      (card_id),
        .load_en      (load_en),
        .load_val     (load_val),
        .fare         (fare),
        .hipass_out   (hipass_out),
        .tx_busy      (tx_busy),
        .balance      (balance),
        .paid         (paid),
        .low_bal      (low_bal),
        .beep         (beep)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic gr, input logic ga, input logic cp,
                                input logic [3:0] id, input logic le,
                                input logic [7:0] lv, input logic [7:0] fr,
                                input logic [3:0] h, input logic b,
                                input logic [7:0] bal, input logic p,
                                input logic lo, input logic bp);
        vec_t v;
        v.gr = gr; v.ga = ga; v.cp = cp; v.id = id; v.le = le; v.lv = lv; v.fr = fr;
        v.h = h; v.b = b; v.bal = bal; v.p = p; v.lo = lo; v.bp = bp;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check after the next rising edge.
    task automatic run_vec(input string tag, input vec_t v);
        vec_t e;
        gate_req = v.gr; gate_ack = v.ga; card_present = v.cp; card_id = v.id;
        load_en = v.le; load_val = v.lv; fare = v.fr;
        sb_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, ".hipass_out"}, int'(hipass_out), int'(e.h));
        chk({tag, ".tx_busy"},    int'(tx_busy),    int'(e.b));
        chk({tag, ".balance"},    int'(balance),    int'(e.bal));
        chk({tag, ".paid"},       int'(paid),       int'(e.p));
        chk({tag, ".low_bal"},    int'(low_bal),    int'(e.lo));
        chk({tag, ".beep"},       int'(beep),       int'(e.bp));
        gate_ack = 1'b0;
        load_en  = 1'b0;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        gate_req = 1'b0; gate_ack = 1'b0; card_present = 1'b0; card_id = 4'h0;
        load_en = 1'b0; load_val = 8'h00; fare = 8'h00;
        #1;
        chk({tag, ".rst.hipass_out"}, int'(hipass_out), 0);
        chk({tag, ".rst.tx_busy"},    int'(tx_busy),    0);
        chk({tag, ".rst.balance"},    int'(balance),    0);
        chk({tag, ".rst.paid"},       int'(paid),       0);
        chk({tag, ".rst.beep"},       int'(beep),       0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        @(negedge clk);

        // Nominal pass: load 20, fare 5, card 3, ack in WAIT_ACK
        tbl[0] = mk(0,0,1,4'h3,1,8'd20,8'd5, 4'h0,0,8'd20,0,0,0);
        tbl[1] = mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0);
        tbl[2] = mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0);
        for (int i = 3; i <= 6; i++)
            tbl[i] = mk(1,0,1,4'h3,0,8'd0,8'd5, 4'h3,1,8'd20,0,0,0);
        tbl[7] = mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0);
        tbl[8] = mk(1,1,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd15,1,0,1);
        tbl[9] = mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd15,0,0,1);
        for (int i = 10; i <= 15; i++)
            tbl[i] = mk(0,0,1,4'h3,0,8'd0,8'd5, 4'h0,0,8'd15,0,0,1);
        tbl[16] = mk(0,0,1,4'h3,0,8'd0,8'd5, 4'h0,0,8'd15,0,0,0);

        do_reset("nominal");
        for (int i = 0; i < 17; i++)
            run_vec($sformatf("nominal[%0d]", i), tbl[i]);

        // Insufficient balance: no transmission, low_bal set
        do_reset("lowbal");
        run_vec("lowbal.load", mk(0,0,1,4'h3,1,8'd3,8'd5, 4'h0,0,8'd3,0,1,0));
        run_vec("lowbal.rise", mk(1,0,1,4'h3,0,8'd0,8'd5, 4'h0,0,8'd3,0,1,0));
        hold(3);
        run_vec("lowbal.late", mk(1,0,1,4'h3,0,8'd0,8'd5, 4'h0,0,8'd3,0,1,0));

        // Invalid card codes or no card
        do_reset("badcard");
        run_vec("badcard.load", mk(0,0,1,4'hF,1,8'd20,8'd5, 4'h0,0,8'd20,0,0,0));
        run_vec("badcard.idF",  mk(1,0,1,4'hF,0,8'd0,8'd5,  4'h0,0,8'd20,0,0,0));
        run_vec("badcard.drop", mk(0,0,1,4'h0,0,8'd0,8'd5,  4'h0,0,8'd20,0,0,0));
        run_vec("badcard.id0",  mk(1,0,1,4'h0,0,8'd0,8'd5,  4'h0,0,8'd20,0,0,0));
        run_vec("badcard.drp2", mk(0,0,0,4'h3,0,8'd0,8'd5,  4'h0,0,8'd20,0,0,0));
        run_vec("badcard.nocp", mk(1,0,0,4'h3,0,8'd0,8'd5,  4'h0,0,8'd20,0,0,0));

        // No ack: timeout to COOLDOWN, late ack ignored, re-arm only after gate_req drops
        do_reset("timeout");
        run_vec("timeout.load", mk(0,0,1,4'h3,1,8'd20,8'd5, 4'h0,0,8'd20,0,0,0));
        run_vec("timeout.rise", mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));
        hold(21);
        run_vec("timeout.end",  mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));
        run_vec("timeout.ack",  mk(1,1,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));
        run_vec("timeout.hold", mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));
        run_vec("timeout.drop", mk(0,0,1,4'h3,0,8'd0,8'd5,  4'h0,0,8'd20,0,0,0));
        run_vec("timeout.re",   mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));

        // Ack on the last WAIT_ACK cycle is still honoured
        do_reset("lastack");
        run_vec("lastack.load", mk(0,0,1,4'h3,1,8'd20,8'd5, 4'h0,0,8'd20,0,0,0));
        run_vec("lastack.rise", mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));
        hold(21);
        run_vec("lastack.ack",  mk(1,1,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd15,1,0,1));

        // Simultaneous saturating top-up and deduction
        do_reset("satded");
        run_vec("satded.load", mk(0,0,1,4'h3,1,8'd250,8'd5, 4'h0,0,8'd250,0,0,0));
        run_vec("satded.rise", mk(1,0,1,4'h3,0,8'd0,8'd5,   4'h0,1,8'd250,0,0,0));
        hold(5);
        run_vec("satded.wait", mk(1,0,1,4'h3,0,8'd0,8'd5,   4'h0,1,8'd250,0,0,0));
        run_vec("satded.ack",  mk(1,1,1,4'h3,1,8'd10,8'd5,  4'h0,1,8'd250,1,0,1));

        // Ack during SEND ends the transmission early
        do_reset("sendack");
        run_vec("sendack.load", mk(0,0,1,4'h3,1,8'd20,8'd5, 4'h0,0,8'd20,0,0,0));
        run_vec("sendack.rise", mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));
        hold(2);
        run_vec("sendack.send", mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h3,1,8'd20,0,0,0));
        run_vec("sendack.ack",  mk(1,1,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd15,1,0,1));

        // Fare raised above balance before ack: no deduction
        do_reset("underflow");
        run_vec("underflow.load", mk(0,0,1,4'h3,1,8'd5,8'd5, 4'h0,0,8'd5,0,0,0));
        run_vec("underflow.rise", mk(1,0,1,4'h3,0,8'd0,8'd5, 4'h0,1,8'd5,0,0,0));
        hold(5);
        run_vec("underflow.ack",  mk(1,1,1,4'h3,0,8'd0,8'd10, 4'h0,1,8'd5,0,1,0));

        // Aborts: gate_req drop in DELAY, card removal in SEND
        do_reset("abort");
        run_vec("abort.load",  mk(0,0,1,4'h3,1,8'd20,8'd5, 4'h0,0,8'd20,0,0,0));
        run_vec("abort.rise",  mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));
        run_vec("abort.grlo",  mk(0,0,1,4'h3,0,8'd0,8'd5,  4'h0,0,8'd20,0,0,0));
        run_vec("abort.rise2", mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));
        hold(2);
        run_vec("abort.cplo",  mk(1,0,0,4'h3,0,8'd0,8'd5,  4'h0,0,8'd20,0,0,0));

        // Saturating top-up in IDLE; stray ack in IDLE ignored
        do_reset("sat");
        run_vec("sat.load1", mk(0,0,1,4'h3,1,8'd250,8'd5, 4'h0,0,8'd250,0,0,0));
        run_vec("sat.load2", mk(0,0,1,4'h3,1,8'd10,8'd5,  4'h0,0,8'd255,0,0,0));
        run_vec("sat.ack",   mk(0,1,1,4'h3,0,8'd0,8'd5,   4'h0,0,8'd255,0,0,0));

        // Asynchronous reset in the middle of SEND
        do_reset("midrst");
        run_vec("midrst.load", mk(0,0,1,4'h3,1,8'd20,8'd5, 4'h0,0,8'd20,0,0,0));
        run_vec("midrst.rise", mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h0,1,8'd20,0,0,0));
        hold(2);
        run_vec("midrst.send", mk(1,0,1,4'h3,0,8'd0,8'd5,  4'h3,1,8'd20,0,0,0));
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.hipass_out", int'(hipass_out), 0);
        chk("midrst.tx_busy",    int'(tx_busy),    0);
        chk("midrst.balance",    int'(balance),    0);
        chk("midrst.paid",       int'(paid),       0);
        @(negedge clk);
        rst = 1'b1;
        gate_req = 1'b0;
        hold(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
